// File: rtl/nm_sim_pkg.sv
// Shared definitions for the NM chip serial register model: FSM state codes,
// uplink sync word, CRC-8 step and packet-length helper.
package nm_sim_pkg;

  typedef logic [3:0] nm_state_t;

  localparam nm_state_t ST_IDLE        = 4'd0;
  localparam nm_state_t ST_RESET_TEST  = 4'd1;
  localparam nm_state_t ST_CMD_SHIFT   = 4'd2;
  localparam nm_state_t ST_OP_BIT      = 4'd3;
  localparam nm_state_t ST_REG_SHIFT   = 4'd4;
  localparam nm_state_t ST_REG_EXEC    = 4'd5;
  localparam nm_state_t ST_REG_TRAILER = 4'd6;
  localparam nm_state_t ST_TX_WAIT     = 4'd7;
  localparam nm_state_t ST_TX_SHIFT    = 4'd8;

  localparam int SYNC_LEN = 13;
  localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 13'b0000000010101;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in,
                                           input logic [7:0] poly);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

  // sync + type + 2-bit header + address + data + CRC-8
  function automatic int pkt_len(input int addr_w, input int data_w);
    return SYNC_LEN + 3 + addr_w + data_w + 8;
  endfunction

endpackage

// File: rtl/nm_sim_reg_model_ser.sv
// Uplink serializer: loads a response packet on start and shifts it out MSB
// first, CLK_DIV clocks per bit, appending a serial CRC-8 over type..data.
module nm_uplink_ser
  import nm_sim_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 16,
  parameter int          CLK_DIV  = 10,
  parameter logic [7:0]  CRC_POLY = 8'h4D
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              abort,
  input  logic              is_ack,
  input  logic              err,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              dout
);

  localparam int PKT_LEN = pkt_len(ADDR_W, DATA_W);
  localparam int LD_W    = SYNC_LEN + 3 + ADDR_W + DATA_W;
  localparam int BC_W    = $clog2(PKT_LEN);
  localparam int DV_W    = $clog2(CLK_DIV);

  logic [LD_W-1:0] sh_q, sh_d;
  logic [7:0]      crc_q, crc_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [DV_W-1:0] div_q, div_d;
  logic            busy_q, busy_d;

  always_comb begin
    sh_d   = sh_q;
    crc_d  = crc_q;
    bc_d   = bc_q;
    div_d  = div_q;
    busy_d = busy_q;
    done   = 1'b0;
    if (abort) begin
      sh_d   = '0;
      crc_d  = '0;
      bc_d   = '0;
      div_d  = '0;
      busy_d = 1'b0;
    end else if (start) begin
      sh_d   = {SYNC_PATTERN, 1'b0, is_ack, err, addr, data};
      crc_d  = '0;
      bc_d   = '0;
      div_d  = DV_W'(CLK_DIV - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (div_q != '0) begin
        div_d = div_q - 1'b1;
      end else begin
        div_d = DV_W'(CLK_DIV - 1);
        if (bc_q == BC_W'(PKT_LEN - 1)) begin
          busy_d = 1'b0;
          done   = 1'b1;
          sh_d   = '0;
          crc_d  = '0;
          bc_d   = '0;
        end else begin
          bc_d = bc_q + 1'b1;
          if (bc_q < BC_W'(LD_W)) begin
            sh_d = {sh_q[LD_W-2:0], 1'b0};
            // sync bits are not covered by the CRC
            if (bc_q >= BC_W'(SYNC_LEN))
              crc_d = crc8_step(crc_q, sh_q[LD_W-1], CRC_POLY);
          end else begin
            crc_d = {crc_q[6:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sh_q   <= '0;
      crc_q  <= '0;
      bc_q   <= '0;
      div_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      crc_q  <= crc_d;
      bc_q   <= bc_d;
      div_q  <= div_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign dout = busy_q & ((bc_q < BC_W'(LD_W)) ? sh_q[LD_W-1] : crc_q[7]);

endmodule

// File: rtl/nm_sim_reg_model.sv
// Behavioural model of the NM chip serial command/register interface:
// downlink frame decode, register file, command capture and uplink responses.
module nm_sim_reg_model
  import nm_sim_pkg::*;
#(
  parameter int         ADDR_W         = 16,
  parameter int         DATA_W         = 16,
  parameter int         NUM_REGS       = 32,
  parameter int         CMD_BITS       = 20,
  parameter int         WR_TRAILER     = 5,
  parameter int         CLK_DIV        = 10,
  parameter int         WRITE_ACK      = 0,
  parameter logic [7:0] CRC_POLY       = 8'h4D,
  parameter int         DEBUG_BUS_SIZE = 4
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      run,
  input  logic                      rx_valid,
  input  logic                      rx_bit,
  output logic                      tx_rdy,
  input  logic                      tx_ok,
  output logic                      dout,
  output logic                      tx_active,
  output logic                      cmd_valid,
  output logic [CMD_BITS-1:0]       cmd_data,
  output logic                      rx_overrun,
  output logic [DEBUG_BUS_SIZE-1:0] debug
);

  localparam int AD_W    = ADDR_W + DATA_W;
  localparam int SH_W    = (CMD_BITS > AD_W) ? CMD_BITS : AD_W;
  localparam int CNT_MAX = (SH_W > WR_TRAILER) ? SH_W : WR_TRAILER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  nm_state_t           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic                type_q, type_d;
  logic                op_q, op_d;
  logic [CMD_BITS-1:0] cmd_data_q, cmd_data_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                rx_overrun_q, rx_overrun_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                tx_ack_q, tx_ack_d;
  logic                tx_err_q, tx_err_d;
  logic [ADDR_W-1:0]   tx_addr_q, tx_addr_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;

  logic                ser_start, ser_busy, ser_done, ser_dout;
  logic [ADDR_W-1:0]   ex_addr;
  logic [DATA_W-1:0]   ex_data;
  logic [IDX_W-1:0]    ex_idx;
  logic                ex_err;

  assign ex_addr = sh_q[AD_W-1 -: ADDR_W];
  assign ex_data = sh_q[DATA_W-1:0];
  assign ex_idx  = ex_addr[IDX_W-1:0];
  // full-width unsigned compare, so high addresses never alias into the file
  assign ex_err  = ({1'b0, ex_addr} >= (ADDR_W + 1)'(NUM_REGS));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    type_d       = type_q;
    op_d         = op_q;
    cmd_data_d   = cmd_data_q;
    cmd_valid_d  = 1'b0;
    rx_overrun_d = 1'b0;
    regs_d       = regs_q;
    tx_ack_d     = tx_ack_q;
    tx_err_d     = tx_err_q;
    tx_addr_d    = tx_addr_q;
    tx_data_d    = tx_data_q;
    ser_start    = 1'b0;
    if (!run) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (rx_valid) begin
            type_d  = rx_bit;
            state_d = ST_RESET_TEST;
          end
        end
        ST_RESET_TEST: begin
          if (rx_valid) state_d = ST_IDLE;
          else          state_d = type_q ? ST_CMD_SHIFT : ST_OP_BIT;
        end
        ST_CMD_SHIFT: begin
          if (cnt_q == CNT_W'(CMD_BITS)) begin
            cmd_data_d  = sh_q[CMD_BITS-1:0];
            cmd_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end else if (rx_valid) begin
            sh_d  = {sh_q[SH_W-2:0], rx_bit};
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_OP_BIT: begin
          if (rx_valid) begin
            op_d    = rx_bit;
            cnt_d   = '0;
            state_d = ST_REG_SHIFT;
          end
        end
        ST_REG_SHIFT: begin
          if (rx_valid) begin
            sh_d  = {sh_q[SH_W-2:0], rx_bit};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(AD_W - 1)) state_d = ST_REG_EXEC;
          end
        end
        ST_REG_EXEC: begin
          cnt_d     = '0;
          tx_addr_d = ex_addr;
          tx_err_d  = ex_err;
          tx_ack_d  = op_q;
          if (op_q) begin
            if (!ex_err) regs_d[ex_idx] = ex_data;
            tx_data_d = ex_err ? '0 : ex_data;
            if (WRITE_ACK != 0)     state_d = ST_TX_WAIT;
            else if (WR_TRAILER == 0) state_d = ST_IDLE;
            else                    state_d = ST_REG_TRAILER;
          end else begin
            tx_data_d = ex_err ? '0 : regs_q[ex_idx];
            state_d   = ST_TX_WAIT;
          end
        end
        ST_REG_TRAILER: begin
          if (rx_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WR_TRAILER - 1)) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end
        end
        ST_TX_WAIT: begin
          rx_overrun_d = rx_valid;
          if (tx_ok) begin
            ser_start = 1'b1;
            state_d   = ST_TX_SHIFT;
          end
        end
        ST_TX_SHIFT: begin
          rx_overrun_d = rx_valid;
          if (ser_done) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      type_q       <= 1'b0;
      op_q         <= 1'b0;
      cmd_data_q   <= '0;
      cmd_valid_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_ack_q     <= 1'b0;
      tx_err_q     <= 1'b0;
      tx_addr_q    <= '0;
      tx_data_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      type_q       <= type_d;
      op_q         <= op_d;
      cmd_data_q   <= cmd_data_d;
      cmd_valid_q  <= cmd_valid_d;
      rx_overrun_q <= rx_overrun_d;
      tx_ack_q     <= tx_ack_d;
      tx_err_q     <= tx_err_d;
      tx_addr_q    <= tx_addr_d;
      tx_data_q    <= tx_data_d;
      regs_q       <= regs_d;
    end
  end

  nm_uplink_ser #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .CLK_DIV  (CLK_DIV),
    .CRC_POLY (CRC_POLY)
  ) u_ser (
    .clk    (clk),
    .rstb   (rstb),
    .start  (ser_start),
    .abort  (!run),
    .is_ack (tx_ack_q),
    .err    (tx_err_q),
    .addr   (tx_addr_q),
    .data   (tx_data_q),
    .busy   (ser_busy),
    .done   (ser_done),
    .dout   (ser_dout)
  );

  always_comb begin
    debug      = '0;
    debug[3:0] = state_q;
  end

  assign tx_rdy     = run & (state_q == ST_TX_WAIT);
  assign tx_active  = run & (state_q == ST_TX_SHIFT) & ser_busy;
  assign dout       = run & ser_dout;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_data   = cmd_data_q;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_nm_sim_reg_model.sv
// Randomized self-checking bench for nm_sim_reg_model: one DUT without and one
// with write acknowledge, compared against a register-file/packet model.
module tb_nm_sim_reg_model;
  import nm_sim_pkg::*;

  logic clk, rstb, run, rx_valid, rx_bit, sel;
  logic tx_ok0, tx_ok1;
  logic rxv0, rxv1;
  logic tx_rdy0, dout0, tx_active0, cmd_valid0, rx_overrun0;
  logic tx_rdy1, dout1, tx_active1, cmd_valid1, rx_overrun1;
  logic [19:0] cmd_data0, cmd_data1;
  logic [3:0]  debug0, debug1;
  logic tx_rdy_s, dout_s, tx_active_s;
  logic [3:0] debug_s;

  int assertions = 0;
  int failures   = 0;
  int ovr_cnt1   = 0;
  int cmdv_cnt0  = 0;
  int rdy_cnt0   = 0;

  logic [15:0] m0 [32];
  logic [15:0] m1 [32];

  assign rxv0 = rx_valid & ~sel;
  assign rxv1 = rx_valid & sel;
  assign tx_rdy_s    = sel ? tx_rdy1    : tx_rdy0;
  assign dout_s      = sel ? dout1      : dout0;
  assign tx_active_s = sel ? tx_active1 : tx_active0;
  assign debug_s     = sel ? debug1     : debug0;

  nm_sim_reg_model #(.WRITE_ACK(0)) dut (
    .clk(clk), .rstb(rstb), .run(run), .rx_valid(rxv0), .rx_bit(rx_bit),
    .tx_rdy(tx_rdy0), .tx_ok(tx_ok0), .dout(dout0), .tx_active(tx_active0),
    .cmd_valid(cmd_valid0), .cmd_data(cmd_data0), .rx_overrun(rx_overrun0),
    .debug(debug0));

  nm_sim_reg_model #(.WRITE_ACK(1)) dut_ack (
    .clk(clk), .rstb(rstb), .run(run), .rx_valid(rxv1), .rx_bit(rx_bit),
    .tx_rdy(tx_rdy1), .tx_ok(tx_ok1), .dout(dout1), .tx_active(tx_active1),
    .cmd_valid(cmd_valid1), .cmd_data(cmd_data1), .rx_overrun(rx_overrun1),
    .debug(debug1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_overrun1) ovr_cnt1++;
    if (cmd_valid0)  cmdv_cnt0++;
    if (tx_rdy0)     rdy_cnt0++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected packet; CRC as remainder of msg(x)*x^8 divided by the polynomial
  function automatic logic [55:0] mk_pkt(input logic ack, input logic err,
                                         input logic [15:0] a, input logic [15:0] d);
    logic [34:0] msg;
    logic [42:0] v;
    logic [12:0] sync;
    msg  = {1'b0, ack, err, a, d};
    v    = {msg, 8'h00};
    sync = 13'b0000000010101;
    for (int i = 42; i >= 8; i--)
      if (v[i]) v[i -: 9] = v[i -: 9] ^ {1'b1, 8'h4D};
    return {sync, msg, v[7:0]};
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_bit   = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_field(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_write(input logic [15:0] a, input logic [15:0] d);
    send_bit(1'b0);
    send_bit(1'b1);
    send_field({16'h0, a}, 16);
    send_field({16'h0, d}, 16);
    send_field($urandom, 5);
    if (a < 32) begin
      if (sel) m1[a] = d;
      else     m0[a] = d;
    end
  endtask

  task automatic send_read(input logic [15:0] a);
    send_bit(1'b0);
    send_bit(1'b0);
    send_field({16'h0, a}, 16);
    send_field($urandom, 16);
  endtask

  function automatic logic [55:0] exp_read(input logic [15:0] a);
    logic [15:0] d;
    if (a >= 32) return mk_pkt(1'b0, 1'b1, a, 16'h0);
    d = sel ? m1[a] : m0[a];
    return mk_pkt(1'b0, 1'b0, a, d);
  endfunction

  task automatic grant();
    int n;
    n = 0;
    while (tx_rdy_s !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    assertions++;
    if (tx_rdy_s !== 1'b1) begin
      $display("FAIL tx_rdy_wait: tx_rdy=%b after %0d cycles, required 1", tx_rdy_s, n);
      failures++;
    end
    if (sel) tx_ok1 = 1'b1;
    else     tx_ok0 = 1'b1;
    @(negedge clk);
    tx_ok0 = 1'b0;
    tx_ok1 = 1'b0;
  endtask

  task automatic capture(input logic [55:0] exp, input string name);
    int bad, first;
    grant();
    assertions++;
    if (tx_active_s !== 1'b1 || tx_rdy_s !== 1'b0) begin
      $display("FAIL %s_start: tx_active=%b tx_rdy=%b, required 1/0", name, tx_active_s, tx_rdy_s);
      failures++;
    end
    bad   = 0;
    first = -1;
    for (int k = 0; k < 56; k++) begin
      for (int j = 0; j < 10; j++) begin
        if (dout_s !== exp[55-k]) begin
          bad++;
          if (first < 0) first = k;
        end
        @(negedge clk);
      end
    end
    assertions++;
    if (bad != 0) begin
      $display("FAIL %s_bits: %0d wrong cycles, first at bit %0d, required packet %h",
               name, bad, first, exp);
      failures++;
    end
    assertions++;
    if (tx_active_s !== 1'b0 || dout_s !== 1'b0 || debug_s !== ST_IDLE) begin
      $display("FAIL %s_end: tx_active=%b dout=%b state=%0d, required 0/0/%0d",
               name, tx_active_s, dout_s, debug_s, ST_IDLE);
      failures++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    assertions++;
    if ({tx_rdy0, dout0, tx_active0, cmd_valid0, rx_overrun0} !== 5'b0 || debug0 !== ST_IDLE
        || cmd_data0 !== 20'h0 || tx_rdy1 !== 1'b0 || dout1 !== 1'b0) begin
      $display("FAIL reset_outputs: rdy=%b dout=%b act=%b cv=%b ovr=%b st=%0d cmd=%h, required zeros/IDLE",
               tx_rdy0, dout0, tx_active0, cmd_valid0, rx_overrun0, debug0, cmd_data0);
      failures++;
    end
    rstb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int rdy0;
    logic [15:0] a;
    sel  = 1'b0;
    rdy0 = rdy_cnt0;
    send_write(16'h0003, 16'hBEEF);
    repeat (2) @(negedge clk);
    assertions++;
    if (rdy_cnt0 != rdy0 || debug0 !== ST_IDLE) begin
      $display("FAIL write_no_resp: tx_rdy cycles=%0d state=%0d, required 0/%0d",
               rdy_cnt0 - rdy0, debug0, ST_IDLE);
      failures++;
    end
    send_read(16'h0003);
    capture(exp_read(16'h0003), "read_beef");
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom_range(0, 31));
      send_write(a, 16'($urandom));
    end
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom_range(0, 31));
      send_read(a);
      capture(exp_read(a), "read_rand");
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] a;
    sel = 1'b0;
    send_read(16'h0040);
    capture(mk_pkt(1'b0, 1'b1, 16'h0040, 16'h0), "read_oor");
    send_write(16'h0040, 16'h5A5A);
    send_read(16'h0000);
    capture(exp_read(16'h0000), "oor_no_alias");
    a = 16'($urandom_range(32, 65535));
    send_write(a, 16'($urandom));
    send_read(a);
    capture(exp_read(a), "read_oor_rand");
  endtask

  task automatic test_write_ack();
    int ovr0;
    sel  = 1'b1;
    ovr0 = ovr_cnt1;
    send_write(16'h0001, 16'h1234);
    @(negedge clk);
    assertions++;
    if (ovr_cnt1 - ovr0 != 5) begin
      $display("FAIL ack_overrun: %0d pulses, required 5", ovr_cnt1 - ovr0);
      failures++;
    end
    capture(mk_pkt(1'b1, 1'b0, 16'h0001, 16'h1234), "write_ack");
    send_write(16'h0045, 16'h7777);
    capture(mk_pkt(1'b1, 1'b1, 16'h0045, 16'h0), "write_ack_oor");
    send_read(16'h0001);
    capture(exp_read(16'h0001), "ack_readback");
    sel = 1'b0;
  endtask

  task automatic test_cmd();
    int cv0, rdy0;
    logic [19:0] p;
    sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p    = (i == 0) ? 20'hA5A5A : 20'($urandom);
      cv0  = cmdv_cnt0;
      rdy0 = rdy_cnt0;
      send_bit(1'b1);
      send_field({12'h0, p}, 20);
      repeat (2) @(negedge clk);
      assertions++;
      if (cmdv_cnt0 - cv0 != 1 || cmd_data0 !== p) begin
        $display("FAIL cmd_capture: pulses=%0d data=%h, required 1/%h", cmdv_cnt0 - cv0, cmd_data0, p);
        failures++;
      end
      assertions++;
      if (rdy_cnt0 != rdy0 || debug0 !== ST_IDLE) begin
        $display("FAIL cmd_no_resp: tx_rdy cycles=%0d state=%0d, required 0/%0d",
                 rdy_cnt0 - rdy0, debug0, ST_IDLE);
        failures++;
      end
    end
  endtask

  task automatic test_reset_pattern();
    int cv0;
    logic [19:0] c_before;
    sel      = 1'b0;
    cv0      = cmdv_cnt0;
    c_before = cmd_data0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_bit   = 1'b1;
    @(negedge clk);
    rx_bit   = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    assertions++;
    if (debug0 !== ST_IDLE || cmdv_cnt0 != cv0 || cmd_data0 !== c_before) begin
      $display("FAIL reset_pattern: state=%0d pulses=%0d cmd=%h, required %0d/0/%h",
               debug0, cmdv_cnt0 - cv0, cmd_data0, ST_IDLE, c_before);
      failures++;
    end
    send_read(16'h0003);
    capture(exp_read(16'h0003), "after_pattern");
  endtask

  task automatic test_run_drop();
    sel = 1'b0;
    send_read(16'h0003);
    grant();
    repeat (200) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    assertions++;
    if (dout0 !== 1'b0 || tx_rdy0 !== 1'b0 || tx_active0 !== 1'b0 || debug0 !== ST_IDLE) begin
      $display("FAIL run_drop: dout=%b tx_rdy=%b act=%b state=%0d, required 0/0/0/%0d",
               dout0, tx_rdy0, tx_active0, debug0, ST_IDLE);
      failures++;
    end
    run = 1'b1;
    @(negedge clk);
    send_read(16'h0003);
    capture(exp_read(16'h0003), "run_retain");
  endtask

  task automatic test_async_reset();
    sel = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2 rstb = 1'b0;
    #1;
    assertions++;
    if (debug0 !== ST_IDLE || tx_rdy0 !== 1'b0 || cmd_data0 !== 20'h0 || dout0 !== 1'b0) begin
      $display("FAIL async_reset: state=%0d tx_rdy=%b cmd=%h dout=%b, required IDLE/0/0/0",
               debug0, tx_rdy0, cmd_data0, dout0);
      failures++;
    end
    for (int i = 0; i < 32; i++) begin
      m0[i] = 16'h0;
      m1[i] = 16'h0;
    end
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    send_read(16'h0003);
    capture(mk_pkt(1'b0, 1'b0, 16'h0003, 16'h0), "reset_clears_3");
    send_read(16'h0000);
    capture(mk_pkt(1'b0, 1'b0, 16'h0000, 16'h0), "reset_clears_0");
    send_read(16'(31));
    capture(mk_pkt(1'b0, 1'b0, 16'd31, 16'h0), "reset_clears_31");
  endtask

  initial begin
    rstb     = 1'b0;
    run      = 1'b1;
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
    sel      = 1'b0;
    tx_ok0   = 1'b0;
    tx_ok1   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m0[i] = 16'h0;
      m1[i] = 16'h0;
    end
    test_reset();
    test_write_read();
    test_out_of_range();
    test_write_ack();
    test_cmd();
    test_reset_pattern();
    test_run_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/nm_sim_reg_model.md
Name: nm_sim_reg_model

Overview:
- Parametrised behavioural model of the neuromodulation (NM) chip's serial command/register interface, used in simulation and FPGA emulation benches.
- Deserialises downlink frames (`rx_valid`/`rx_bit`), decodes them as register write, register read or opaque command, and keeps a resettable register file.
- Serialises uplink response packets (sync, type, header, address, data, CRC-8) at a divided bit rate, gated by a `tx_rdy`/`tx_ok` handshake.
- Adds to the previous fixed-width model: configurable widths and depth, address range checking, optional write acknowledge, command capture, and overrun reporting.

Parameters:
- ADDR_W, 16, address field width in bits.
- DATA_W, 16, data field width in bits.
- NUM_REGS, 32, register file depth; legal addresses are 0..NUM_REGS-1.
- CMD_BITS, 20, payload bits of a command frame.
- WR_TRAILER, 5, trailing bits after a write frame; received and discarded.
- CLK_DIV, 10, clk cycles per uplink bit (must be >= 2).
- WRITE_ACK, 0, 1 = send a response packet after every write.
- CRC_POLY, 8'h4D, CRC-8 polynomial (x^8+x^6+x^3+x^2+1); initial value 8'h00.
- DEBUG_BUS_SIZE, 4, debug width (must be >= 4).

Ports:
- clk  in  1  clock.
- rstb  in  1  reset, asynchronous, active-low.
- run  in  1  enable; low forces IDLE.
- rx_valid  in  1  one-cycle strobe qualifying rx_bit.
- rx_bit  in  1  downlink bit, MSB first.
- tx_rdy  out  1  response packet pending.
- tx_ok  in  1  grant to start transmission.
- dout  out  1  uplink serial bit.
- tx_active  out  1  high while a packet is being shifted out.
- cmd_valid  out  1  one-cycle pulse; a command frame is complete.
- cmd_data  out  CMD_BITS  last command payload; held until the next command.
- rx_overrun  out  1  one-cycle pulse when rx_valid arrives while busy in TX_WAIT/TX_SHIFT.
- debug  out  DEBUG_BUS_SIZE  {zeros, state[3:0]}.

Behaviour:
- Reset (rstb low) clears every register file entry, cmd_data, the shift registers and the CRC to 0.
- Outputs under reset: tx_rdy=0, dout=0, tx_active=0, cmd_valid=0, rx_overrun=0, state=IDLE.
- run=0 forces IDLE synchronously: any transmission is aborted, dout=0, tx_rdy=0; register contents are kept.
- Downlink frame, each field MSB first, one bit per rx_valid:
  - type bit: 1 = command, 0 = register op;
  - register op: op bit (1 = write), then ADDR_W address bits, then DATA_W data bits (ignored for a read);
  - write only: WR_TRAILER further bits.
- States:
  - IDLE: bit counter cleared. rx_valid latches the type bit -> RESET_TEST.
  - RESET_TEST (one cycle): rx_valid high here is a reset/abort pattern; the bit is discarded -> IDLE. Otherwise -> CMD_SHIFT if type=1, else OP_BIT.
  - CMD_SHIFT: shift CMD_BITS bits. On the cycle after the last bit, load cmd_data and pulse cmd_valid -> IDLE.
  - OP_BIT: next rx_valid latches op -> REG_SHIFT.
  - REG_SHIFT: shift ADDR_W+DATA_W bits -> REG_EXEC.
  - REG_EXEC (one cycle):
    - set err = (addr >= NUM_REGS);
    - write: store data if !err; -> TX_WAIT if WRITE_ACK, else REG_TRAILER;
    - read: latch regfile[addr], or 0 if err; -> TX_WAIT.
  - REG_TRAILER: count WR_TRAILER rx_valid -> IDLE. With WRITE_ACK=1, the trailer bits arrive during TX states and raise rx_overrun.
  - TX_WAIT: tx_rdy=1. tx_ok sampled high -> TX_SHIFT next cycle. tx_rdy stays high until that transition.
  - TX_SHIFT: tx_active=1. Each bit is held on dout for exactly CLK_DIV cycles; the first bit appears in the first TX_SHIFT cycle. After the last CRC bit period -> IDLE, dout=0.
- Uplink packet, MSB first:
  - sync 13'b0000000010101;
  - type 0;
  - hdr[1:0] = {is_write_ack, err};
  - addr (ADDR_W);
  - data (DATA_W; written value for an ack, 0 if err);
  - crc (8 bits).
  - Length = 13+3+ADDR_W+DATA_W+8 (56 with default parameters).
- CRC:
  - serial over type, hdr, addr and data bits in transmit order;
  - feedback fb = crc[7] ^ bit; crc <= {crc[6:0],0} ^ (fb ? CRC_POLY : 0);
  - transmitted MSB first.
- Address comparison is unsigned over the full ADDR_W; no wrap-around into the register file.
- rx_valid on the same cycle as an FSM transition is consumed by the current state.

Decomposition:
- Package nm_sim_pkg:
  - state enum (4-bit);
  - SYNC_PATTERN and SYNC_LEN;
  - CRC-8 step function;
  - packet-length helper function.
- Sub-module nm_uplink_ser:
  - bit-rate divider, load-and-shift register, serial CRC, bit counter;
  - start/busy/done interface.
- The FSM and register file remain in nm_sim_reg_model.

Test Plan:
- Write addr 0x0003 data 0xBEEF (WRITE_ACK=0), then read 0x0003 -> after tx_ok, packet = sync, 3'b000, 0x0003, 0xBEEF, crc matching the nm_sim_pkg golden function; each bit lasts 10 clk; 56 bits total.
- Read addr 0x0040 (>= NUM_REGS) -> hdr = 2'b01, data = 0x0000; a write to 0x0040 changes no register.
- WRITE_ACK=1: write 0x0001 <- 0x1234 -> packet hdr = 2'b10, data = 0x1234; trailer bits pulse rx_overrun 5 times.
- Command frame: type 1 + 20 bits 0xA5A5A -> cmd_valid pulses once, cmd_data = 0xA5A5A; tx_rdy stays 0.
- Reset pattern: rx_valid on two consecutive cycles -> FSM back in IDLE, no register or cmd change; the next valid frame decodes normally.
- Drop run mid-packet at bit 20 -> dout=0, tx_rdy=0, IDLE next cycle; register contents retained. Assert rstb mid-frame -> all registers read back 0.
